// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyphs, segment indices and counter sizing for the 7-segment scan driver
package seg7_pkg;

  // Hex glyphs, segments[6:0] = {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Width of a counter running 0..div-1; never narrower than one bit so
  // that degenerate dividers (1 digit, 1 frame) still get a legal vector.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg7_hex_rom.sv
// rtl/seg7_hex_rom.sv - combinational nibble to 7-segment glyph lookup
// Ports:
//   nibble  in  4  hex digit to render
//   glyph   out 7  active-high segments {g,f,e,d,c,b,a}
module seg7_hex_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed multi-digit 7-segment display driver
// Ports:
//   clk         in  1             system clock
//   rst_n       in  1             synchronous reset, active-low
//   load        in  1             capture value/dp_in/lz_en/blink_mask into shadow
//   value       in  4*NUM_DIGITS  hex nibbles, nibble 0 = rightmost digit
//   dp_in       in  NUM_DIGITS    decimal point per digit
//   lz_en       in  1             leading-zero suppression enable
//   blink_mask  in  NUM_DIGITS    1 = digit blinks
//   segments    out 7             registered segment lines {g,f,e,d,c,b,a}
//   dp          out 1             registered decimal point of the active digit
//   digit_en    out NUM_DIGITS    registered one-hot digit enable
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int BLINK_DIV  = 64,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en
);
  import seg7_pkg::*;

  localparam int CW = cnt_width(SCAN_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);
  localparam int FW = cnt_width(BLINK_DIV);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV ||
      NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLINK_DIV < 1) begin : g_bad_params
    $error("seg7_scan_mux: illegal parameter combination");
  end

  // Scan state
  logic [CW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  // Shadow registers, all captured on the same edge
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;

  // Per-digit selection for the active index
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            nibble;
  logic                  dp_sel;
  logic                  blink_sel;
  logic                  lz_sel;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic [6:0]            glyph;
  logic                  in_blank;
  logic                  blanked;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (sh_value[4*NUM_DIGITS-1 -: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (sh_value[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nibble    = 4'h0;
    dp_sel    = 1'b0;
    blink_sel = 1'b0;
    lz_sel    = 1'b0;
    en_nxt    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble    = sh_value[4*i +: 4];
        dp_sel    = sh_dp[i];
        blink_sel = sh_blink[i];
        lz_sel    = upper_zero[i];
        en_nxt[i] = 1'b1;
      end
    end
  end

  seg7_hex_rom u_hex_rom (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Digit 0 is exempt from leading-zero suppression so a zero value still shows "0"
  always_comb begin
    in_blank = (32'(slot_cnt) < BLANK_CYC);
    blanked  = in_blank
            || (!blink_on && blink_sel)
            || (sh_lz && (idx != '0) && lz_sel);
    seg_nxt  = blanked ? SEG_OFF : glyph;
    dp_nxt   = !blanked && dp_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_lz    <= 1'b0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_blink <= blink_mask;
      sh_lz    <= lz_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      if (idx == IDX_LAST) begin
        idx <= '0;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Polarity is applied only here so all internal logic stays active-high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments <= {7{POL}};
      dp       <= POL;
      digit_en <= {NUM_DIGITS{POL}};
    end else begin
      segments <= seg_nxt ^ {7{POL}};
      dp       <= dp_nxt ^ POL;
      digit_en <= en_nxt ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - scoreboard bench for seg7_scan_mux, active-high and active-low instances
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_mask = '0;

  logic [6:0]  seg_hi, seg_lo;
  logic        dp_hi, dp_lo;
  logic [3:0]  en_hi, en_lo;

  always #5 clk = ~clk;

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
                  .BLINK_DIV(BD), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .lz_en(lz_en), .blink_mask(blink_mask),
    .segments(seg_hi), .dp(dp_hi), .digit_en(en_hi)
  );

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
                  .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .lz_en(lz_en), .blink_mask(blink_mask),
    .segments(seg_lo), .dp(dp_lo), .digit_en(en_lo)
  );

  logic [6:0] glyph_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic [11:0] exp_q [$];
  int total = 0;
  int bad = 0;

  // Reference state: cycles since reset release and the shadow contents
  int          t_model = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;
  logic [3:0]  m_bm = '0;

  // Expected {segments, dp, digit_en} (active-high) after the edge that
  // follows t cycles of scanning, from pure arithmetic on elapsed time.
  function automatic logic [11:0] model(input int t, input logic [15:0] v,
                                        input logic [3:0] d, input logic lz,
                                        input logic [3:0] bm);
    int          slot;
    int          dig;
    bit          phase_on;
    bit          blank;
    logic [6:0]  s;
    logic        p;
    logic [3:0]  en;
    logic [15:0] upper;
    slot     = t % SD;
    dig      = (t / SD) % ND;
    phase_on = ((t / (SD * ND * BD)) % 2) == 0;
    upper    = v >> (4 * dig);
    blank    = (slot < BC) || (!phase_on && bm[dig]) || (lz && dig > 0 && upper == 16'h0);
    en       = 4'b0001 << dig;
    s        = blank ? 7'b0 : glyph_tab[v[4*dig +: 4]];
    p        = blank ? 1'b0 : d[dig];
    return {s, p, en};
  endfunction

  task automatic drive(input logic r, input logic ld, input logic [15:0] v,
                       input logic [3:0] d, input logic lz, input logic [3:0] bm);
    @(negedge clk);
    rst_n = r; load = ld; value = v; dp_in = d; lz_en = lz; blink_mask = bm;
    if (!r) begin
      exp_q.push_back(12'h000);
      t_model = 0;
      m_val = '0; m_dp = '0; m_lz = 1'b0; m_bm = '0;
    end else begin
      exp_q.push_back(model(t_model, m_val, m_dp, m_lz, m_bm));
      t_model++;
      if (ld) begin
        m_val = v; m_dp = d; m_lz = lz; m_bm = bm;
      end
    end
  endtask

  // Data inputs are scrambled while load is low so shadow holding is exercised
  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  // Monitor: one comparison per instance whenever an expectation is pending
  initial begin
    logic [11:0] e;
    logic [11:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {seg_hi, dp_hi, en_hi};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL active_high t=%0t got seg=%b dp=%b en=%b want seg=%b dp=%b en=%b",
                   $time, got[11:5], got[4], got[3:0], e[11:5], e[4], e[3:0]);
        end
        got = {seg_lo, dp_lo, en_lo};
        total++;
        if (got !== ~e) begin
          bad++;
          $display("FAIL active_low t=%0t got seg=%b dp=%b en=%b want seg=%b dp=%b en=%b",
                   $time, got[11:5], got[4], got[3:0], ~e[11:5], ~e[4], ~e[3:0]);
        end
      end
    end
  end

  initial begin
    // Reset held for three edges
    repeat (3) drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0);
    idle(8);

    // Plain hex scan
    drive(1'b1, 1'b1, 16'h1A2F, 4'h0, 1'b0, 4'h0);
    idle(64);

    // Leading-zero suppression, including value 0
    drive(1'b1, 1'b1, 16'h0005, 4'h0, 1'b1, 4'h0);
    idle(32);
    drive(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1, 4'h0);
    idle(32);

    // Blink on digit 2 over several blink half-periods
    drive(1'b1, 1'b1, 16'h8888, 4'h0, 1'b0, 4'b0100);
    idle(260);

    // Atomic reload in the middle of the digit 1 slot
    drive(1'b1, 1'b1, 16'h4444, 4'h0, 1'b0, 4'h0);
    while ((t_model % (SD * ND)) != (SD + SD / 2)) idle(1);
    drive(1'b1, 1'b1, 16'h3333, 4'h0, 1'b0, 4'h0);
    idle(40);

    // Decimal point on digit 0
    drive(1'b1, 1'b1, 16'h0000, 4'b0001, 1'b0, 4'h0);
    idle(40);

    // Reset mid-scan with load asserted: reset must win
    drive(1'b0, 1'b1, 16'hFFFF, 4'hF, 1'b1, 4'hF);
    idle(20);

    // Randomized traffic with occasional loads and resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0)
        drive(1'b0, 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      else if ($urandom_range(0, 39) == 0)
        drive(1'b1, 1'b1, rand_value(), 4'($urandom), 1'($urandom), 4'($urandom));
      else
        idle(1);
    end

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Multi-digit, time-multiplexed 7-segment display driver. It holds a shadow copy of an N-digit hex value and scans one digit at a time onto shared segment lines, with one enable per digit. Each slot starts with an anti-ghosting blank interval. Leading-zero suppression, per-digit blink and per-digit decimal points are supported. It sits between core logic and the display pins, replacing the single-digit combinational decoder.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 1000, clk cycles per digit slot (>=2)
BLANK_CYC, 16, cycles at the start of each slot with all segments off (0..SCAN_DIV-1)
BLINK_DIV, 64, full scan frames per blink half-period (>=1)
ACTIVE_LOW, 0, 1 = segments, dp and digit_en are driven active-low

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
load  in  1  capture value, dp_in, lz_en, blink_mask into the shadow registers this cycle
value  in  4*NUM_DIGITS  hex nibbles; nibble 0 (LSBs) = rightmost digit
dp_in  in  NUM_DIGITS  decimal point per digit
lz_en  in  1  leading-zero suppression enable
blink_mask  in  NUM_DIGITS  1 = digit blinks
segments  out  7  bit0=a(top), bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g(middle)
dp  out  1  decimal point of the active digit
digit_en  out  NUM_DIGITS  one-hot enable of the active digit

Behaviour:
- Reset (rst_n=0 at a clk edge): slot counter=0, digit index=0, frame counter=0, blink phase=ON, all shadow registers=0. Outputs are all inactive: segments, dp and digit_en off (0s, or 1s if ACTIVE_LOW). Reset mid-scan takes priority over load and counting.
- Shadow load: when load=1, all four shadow fields update together at the edge, so no partial-digit tearing occurs. The new data is visible on the pins 1 cycle later, in the current slot. Without load, the shadow registers hold.
- Slot counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances; the index wraps from NUM_DIGITS-1 to 0.
- Frame counter increments each time the index wraps to 0. At BLINK_DIV-1 it wraps to 0 and the blink phase toggles.
- Digit visibility (combinational on state, then registered):
  - The digit is blanked if slot counter < BLANK_CYC.
  - The digit is blanked if blink phase=OFF and blink_mask[idx]=1.
  - The digit is blanked if lz_en=1, idx>0, and nibbles idx..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed by LZ, so value 0 shows "0".
  - When blanked: segments and dp are off, but digit_en stays asserted for idx.
- Hex glyphs, segments[6:0] active-high:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- dp = dp_in shadow[idx] unless the digit is blanked.
- All outputs are registered: pins reflect the counter/index state of the previous cycle (1-cycle latency). digit_en is always exactly one-hot after the first post-reset edge.
- ACTIVE_LOW=1 inverts segments, dp and digit_en at the output register only; internal logic is unchanged.
- NUM_DIGITS=1: the index is constant 0 and LZ has no effect.
- Parameter violations (SCAN_DIV<2, BLANK_CYC>=SCAN_DIV) are flagged by an elaboration-time assertion.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 glyph constants;
  - SEG_OFF = 7'b0000000;
  - segment bit-index constants;
  - the function for the counter width, $clog2 of the divider.
- One sub-module, seg7_hex_rom: a pure combinational nibble-to-glyph lookup (4 in, 7 out), instanced once on the selected nibble.

Test Plan:
Use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=2, ACTIVE_LOW=0 unless stated.
1. Reset with rst_n=0 for 3 cycles, then release -> segments=0, dp=0, digit_en=0000 during reset; the first post-release output cycle has digit_en=0001 and segments=0 (blank interval).
2. Load value=16'h1A2F, lz_en=0 -> per 32-cycle frame:
   - digit_en=0001 shows 1110001 (F); 0010 shows 1011011 (2); 0100 shows 1110111 (A); 1000 shows 0000110 (1);
   - each slot gives 2 blank cycles followed by 6 glyph cycles.
3. Load value=16'h0005, lz_en=1 -> digits 3..1 are blank with digit_en still cycling; digit 0 shows 1101101. Load value=16'h0000 -> digit 0 shows 0111111 and digits 3..1 are blank.
4. Load blink_mask=4'b0100, value=16'h8888 -> digit 2 shows 1111111 for 2 frames, is blank for 2 frames, and repeats; the other digits are steady 1111111.
5. Pulse load with value=16'h3333 in the middle of the digit 1 slot, while 16'h4444 is displayed -> the next cycle shows 1001111 on digit 1. No cycle mixes old and new data, and the scan position is unaffected.
6. With ACTIVE_LOW=1, load dp_in=4'b0001, value=16'h0000, lz_en=0 -> during reset all outputs are 1. The active digit_en bit is 0; digit 0 shows segments=1000000 with dp=0, and the other digits show dp=1.
